r_rotate_seq: RTL
=================

Name: r_rotate_seq

Overview:
- Iterative 16-bit right rotate/shift unit for the execute stage. It is the right-direction counterpart to the existing combinational left rotator.
- Serves ROR, SRL and SRA instructions from the multicycle ALU path.
- Applies one log-step stage (by 1, 2, 4, 8) per clock, gated by the matching Cnt bit.
- Uses a valid/ready handshake on both input and output, with fixed latency.

Parameters:
- N, 16, data width; only 16 is supported.
- C, 4, count width; log2(N).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset. One clock; reset asynchronous, active-low.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request.
- In  in  16  operand.
- Cnt  in  4  shift/rotate amount, 0..15.
- Op  in  2  operation: 00 ROR, 01 SRL, 10 SRA, 11 reserved (executes as ROR).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- Out  out  16  result.
- Zero  out  1  Out == 16'h0000; valid whenever out_valid is high.

Behaviour:
- States:
  - IDLE: in_ready=1, out_valid=0.
  - BUSY: step counter 0..3; in_ready=0, out_valid=0.
  - DONE: out_valid=1, in_ready=0.
- Reset (async, rst_n low):
  - state=IDLE, step=0, data/cnt/op regs=0.
  - Out=0, Zero=1, out_valid=0, in_ready=1 in the cycle reset deasserts.
- Accept: on an edge with IDLE and in_valid=1, capture In, Cnt, Op and go BUSY with step=0. No accept in BUSY or DONE; in_valid is ignored there.
- Step k (edges 1..4 after accept):
  - If cnt_reg[k]=1, data is moved right by 2^k; otherwise data holds.
  - Fill bits: ROR takes the low bits that wrap around; SRL fills with 0; SRA fills with the captured In[15].
  - After k=3, go DONE.
- Latency: out_valid rises exactly 4 cycles after the accept edge, independent of Cnt. Cnt=0 still takes 4 cycles and returns In unchanged.
- DONE:
  - Out and Zero are held stable while out_ready=0, for any number of cycles.
  - On an edge with out_ready=1, go IDLE.
  - Minimum issue interval is 6 cycles (accept, 4 steps, handoff).
- Out is driven directly from the data register.
- Sign fill for SRA uses the captured In[15], not the evolving register. With fixed right-moving stages these are equivalent; the captured bit is required for clarity.
- Simultaneous events: out_ready and in_valid in the same DONE cycle complete the handoff only. The new request is accepted in the next IDLE cycle.
- Reset mid-BUSY or mid-DONE aborts immediately: the result is lost and out_valid drops asynchronously.
- Out is registered (no combinational path from In to Out). in_ready and out_valid are decoded from state only.
- Ranges: Cnt is unsigned 0..15. Rotation is modulo 16. Shifts never exceed 15, so there is no all-fill case except SRA of a negative value by 15.

Decomposition:
- Shared package (alu_pkg): Op encodings ROR=2'b00, SRL=2'b01, SRA=2'b10; state encodings IDLE/BUSY/DONE; constants N=16, C=4.
- Sub-module r_rot_stage: combinational single-stage right mover.
  - Inputs: In[15:0], amount select k[1:0], enable, Op, sign.
  - Output: Out[15:0].
  - The top level instantiates one r_rot_stage and reuses it each BUSY cycle, indexed by step.
- The top level holds the FSM, step counter and registers.

Test Plan:
- ROR: In=16'h1234, Cnt=4, Op=00 -> Out=16'h4123, out_valid exactly 4 cycles after the accept edge, Zero=0.
- SRL: In=16'h8000, Cnt=15, Op=01 -> Out=16'h0001. SRA: same In/Cnt, Op=10 -> Out=16'hFFFF. SRA: In=16'h7FF0, Cnt=4 -> Out=16'h07FF.
- Zero/no-op: In=16'hBEEF, Cnt=0, ROR -> Out=16'hBEEF after 4 cycles. SRL In=16'h0001, Cnt=1 -> Out=16'h0000, Zero=1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> Out stable, in_ready=0, a new in_valid is ignored. Raise out_ready -> IDLE next cycle, then the pending request is accepted.
- Reset mid-BUSY: assert rst_n=0 at step 2 -> out_valid=0 and Out=0 immediately. After release, in_ready=1 and a fresh ROR In=16'h0001, Cnt=15 -> Out=16'h0002.
- Randomised sweep: all Cnt 0..15 × Op × random In, checked against a reference model, with random out_ready stalls and back-to-back requests.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage shift/rotate units: operation
// codes, the sequencer state encoding and the datapath widths.
package alu_pkg;

  localparam int ALU_N = 16;
  localparam int ALU_C = 4;

  localparam logic [1:0] OP_ROR = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/r_rot_stage.sv
// One combinational log-step of a 16-bit right mover: moves the operand right
// by 2^k when enabled, filling per operation (wrap, zero or sign).
module r_rot_stage
  import alu_pkg::*;
(
  input  logic [15:0] In,
  input  logic [1:0]  k,
  input  logic        enable,
  input  logic [1:0]  Op,
  input  logic        sign,
  output logic [15:0] Out
);

  logic [3:0]  amt;
  logic [31:0] rot_ext;
  logic [15:0] shr;
  logic [15:0] fill;
  logic [15:0] moved;

  always_comb begin
    amt     = 4'd1 << k;
    // Rotating the doubled word lets the wrapped low bits fall into place.
    rot_ext = {In, In} >> amt;
    shr     = In >> amt;
    fill    = ~(16'hFFFF >> amt);
    case (Op)
      OP_SRL:  moved = shr;
      OP_SRA:  moved = sign ? (shr | fill) : shr;
      default: moved = rot_ext[15:0];
    endcase
    Out = enable ? moved : In;
  end

endmodule

// File: rtl/r_rotate_seq.sv
// Iterative 16-bit right rotate/shift: one log-step per clock over four
// cycles, with a valid/ready handshake on both sides and fixed latency.
module r_rotate_seq
  import alu_pkg::*;
#(
  parameter int N = ALU_N,
  parameter int C = ALU_C
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] In,
  input  logic [C-1:0] Cnt,
  input  logic [1:0]   Op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] Out,
  output logic         Zero
);

  state_e       state_q, state_d;
  logic [1:0]   step_q, step_d;
  logic [N-1:0] data_q, data_d;
  logic [C-1:0] cnt_q, cnt_d;
  logic [1:0]   op_q, op_d;
  logic         sign_q, sign_d;
  logic [N-1:0] stage_out;

  // The single stage is time-shared: step selects which Cnt bit and amount.
  r_rot_stage u_stage (
    .In     (data_q),
    .k      (step_q),
    .enable (cnt_q[step_q]),
    .Op     (op_q),
    .sign   (sign_q),
    .Out    (stage_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      step_q  <= 2'd0;
      data_q  <= '0;
      cnt_q   <= '0;
      op_q    <= 2'b00;
      sign_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      sign_q  <= sign_d;
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    sign_d  = sign_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = In;
          cnt_d   = Cnt;
          op_d    = Op;
          sign_d  = In[N-1];
          step_d  = 2'd0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        data_d = stage_out;
        step_d = step_q + 2'd1;
        if (step_q == 2'd3) state_d = DONE;
      end
      DONE: begin
        // A request arriving alongside out_ready waits for the next IDLE cycle.
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign Out       = data_q;
  assign Zero      = (data_q == '0);

endmodule
